// File: rtl/raster_tbuf_writer_pkg.sv
// raster_tbuf_writer_pkg: tile header layout, header size and writer FSM states shared by the raster tile-buffer writer.
package raster_tbuf_writer_pkg;

    localparam int TILE_HEADER_SIZEW = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIDS,
        ST_HDR0,
        ST_HDR1,
        ST_DRAIN
    } state_t;

    // word0 occupies the low 32 bits, word1 the high 32 bits
    typedef struct packed {
        logic [15:0] pids_count;
        logic [15:0] pids_offset;
        logic [15:0] pos_y;
        logic [15:0] pos_x;
    } tile_header_t;

    function automatic logic [31:0] hdr_word(input tile_header_t h, input logic sel);
        return sel ? {h.pids_count, h.pids_offset} : {h.pos_y, h.pos_x};
    endfunction

endpackage

// File: rtl/raster_tbuf_writer_if.sv
// raster_tbuf_writer_if: binned beat stream plus memory write request/ack bus; master is the writer, slave the environment.
interface raster_tbuf_writer_if #(
    parameter int W_ADDR_BITS = 30,
    parameter int PID_BITS    = 16
);
    logic                   in_valid;
    logic [15:0]            in_tile_x;
    logic [15:0]            in_tile_y;
    logic [PID_BITS-1:0]    in_pid;
    logic                   in_tile_last;
    logic                   in_frame_last;
    logic                   in_ready;
    logic                   mem_req_valid;
    logic [W_ADDR_BITS-1:0] mem_req_addr;
    logic [31:0]            mem_req_data;
    logic                   mem_req_ready;
    logic                   mem_ack_valid;

    modport master (
        input  in_valid, in_tile_x, in_tile_y, in_pid, in_tile_last, in_frame_last,
        output in_ready,
        output mem_req_valid, mem_req_addr, mem_req_data,
        input  mem_req_ready, mem_ack_valid
    );

    modport slave (
        output in_valid, in_tile_x, in_tile_y, in_pid, in_tile_last, in_frame_last,
        input  in_ready,
        input  mem_req_valid, mem_req_addr, mem_req_data,
        output mem_req_ready, mem_ack_valid
    );
endinterface

// File: rtl/raster_tbuf_wr_pending.sv
// raster_tbuf_wr_pending: saturating count of fired-but-unacked writes; full also counts a request still held for issue.
module raster_tbuf_wr_pending #(
    parameter int MAX_PENDING = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_resv,
    output logic o_empty,
    output logic o_full
);
    localparam int CW = $clog2(MAX_PENDING + 1) + 1;

    logic [CW-1:0] r_count;

    // acks with nothing outstanding (e.g. stale acks after a reset) are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_count <= '0;
        else       r_count <= r_count + CW'(i_inc) - CW'(i_dec && (r_count != '0));
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count + CW'(i_resv)) >= CW'(MAX_PENDING);

endmodule

// File: rtl/raster_tbuf_writer.sv
// raster_tbuf_writer: writes per-tile pid lists and 2-word tile headers; RASTER_TBUF_STATS_EN adds pid statistics outputs.
module raster_tbuf_writer
    import raster_tbuf_writer_pkg::*;
#(
    parameter int W_ADDR_BITS = 30,
    parameter int PID_BITS    = 16,
    parameter int TILE_BITS   = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [W_ADDR_BITS-1:0] i_cfg_tbuf_addr,
    input  logic [W_ADDR_BITS-1:0] i_cfg_pbuf_addr,
    input  logic                   i_start,
    raster_tbuf_writer_if.master   bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [TILE_BITS-1:0]   o_tile_count,
    output logic                   o_error
`ifdef RASTER_TBUF_STATS_EN
    ,
    output logic [31:0]            o_stat_pid_total,
    output logic [15:0]            o_stat_max_pids
`endif
);
    state_t                 r_state, w_next;
    logic                   r_req_valid;
    logic [W_ADDR_BITS-1:0] r_req_addr;
    logic [31:0]            r_req_data;
    logic [W_ADDR_BITS-1:0] r_pid_ptr, r_first_addr;
    logic [15:0]            r_tile_x, r_tile_y, r_count;
    logic                   r_in_tile, r_frame_last, r_error;
    logic [TILE_BITS-1:0]   r_tile_count;
    logic                   w_fire, w_full, w_empty, w_slot, w_accept, w_issue, w_in_ready, w_done;
    logic [15:0]            w_count_next;
    logic                   w_count_ovf, w_offset_ovf;
    logic [W_ADDR_BITS-1:0] w_hdr_addr, w_offset;
    tile_header_t           w_hdr;

    assign w_fire       = r_req_valid && bus.mem_req_ready;
    assign w_slot       = (!r_req_valid || bus.mem_req_ready) && !w_full;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_count_next = r_in_tile ? r_count + 16'd1 : 16'd1;
    assign w_count_ovf  = r_in_tile && (r_count == 16'hFFFF);
    assign w_hdr_addr   = i_cfg_tbuf_addr + W_ADDR_BITS'(r_tile_count) * W_ADDR_BITS'(TILE_HEADER_SIZEW);
    // the reader adds hdr+2 back, so the offset is relative to the word after the header
    assign w_offset     = r_first_addr - w_hdr_addr - W_ADDR_BITS'(TILE_HEADER_SIZEW);
    assign w_offset_ovf = |w_offset[W_ADDR_BITS-1:16];
    assign w_hdr        = '{pids_count: r_count, pids_offset: w_offset[15:0], pos_y: r_tile_y, pos_x: r_tile_x};

    raster_tbuf_wr_pending #(.MAX_PENDING(MAX_PENDING)) u_pending (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_fire),
        .i_dec   (bus.mem_ack_valid),
        .i_resv  (r_req_valid),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  w_next = i_start ? ST_PIDS : ST_IDLE;
            ST_PIDS:  w_next = (w_accept && bus.in_tile_last) ? ST_HDR0 : ST_PIDS;
            ST_HDR0:  w_next = w_issue ? ST_HDR1 : ST_HDR0;
            ST_HDR1:  w_next = w_issue ? (r_frame_last ? ST_DRAIN : ST_PIDS) : ST_HDR1;
            ST_DRAIN: w_next = w_done ? ST_IDLE : ST_DRAIN;
            default:  w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: beat acceptance, header issue, completion
    always_comb begin
        w_in_ready = (r_state == ST_PIDS) && w_slot;
        w_issue    = ((r_state == ST_HDR0) || (r_state == ST_HDR1)) && w_slot;
        w_done     = (r_state == ST_DRAIN) && w_empty && !r_req_valid;
        o_busy     = (r_state != ST_IDLE);
    end

    // single-entry request register; fields hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
        end else if (w_accept) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= r_pid_ptr;
            r_req_data  <= {{(32-PID_BITS){1'b0}}, bus.in_pid};
        end else if (w_issue) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= (r_state == ST_HDR1) ? w_hdr_addr + W_ADDR_BITS'(1) : w_hdr_addr;
            r_req_data  <= hdr_word(w_hdr, r_state == ST_HDR1);
        end else if (w_fire) begin
            r_req_valid <= 1'b0;
        end
    end

    // per-tile capture, pid pointer, tile counter and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pid_ptr    <= '0;
            r_first_addr <= '0;
            r_tile_x     <= '0;
            r_tile_y     <= '0;
            r_count      <= '0;
            r_in_tile    <= 1'b0;
            r_frame_last <= 1'b0;
            r_error      <= 1'b0;
            r_tile_count <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_pid_ptr    <= i_cfg_pbuf_addr;
            r_in_tile    <= 1'b0;
            r_error      <= 1'b0;
            r_tile_count <= '0;
        end else begin
            if (w_accept) begin
                r_pid_ptr <= r_pid_ptr + W_ADDR_BITS'(1);
                r_count   <= w_count_next;
                r_in_tile <= !bus.in_tile_last;
                if (!r_in_tile) begin
                    r_first_addr <= r_pid_ptr;
                    r_tile_x     <= bus.in_tile_x;
                    r_tile_y     <= bus.in_tile_y;
                end
                if (bus.in_tile_last) r_frame_last <= bus.in_frame_last;
                if (w_count_ovf) r_error <= 1'b1;
            end
            if (w_issue && (r_state == ST_HDR1)) begin
                r_tile_count <= r_tile_count + TILE_BITS'(1);
                if (w_offset_ovf) r_error <= 1'b1;
            end
        end
    end

`ifdef RASTER_TBUF_STATS_EN
    logic [31:0] r_stat_total;
    logic [15:0] r_stat_max;

    // frame totals fold in each tile's count as its last beat is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_total <= '0;
            r_stat_max   <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_stat_total <= '0;
            r_stat_max   <= '0;
        end else if (w_accept && bus.in_tile_last) begin
            r_stat_total <= r_stat_total + 32'(w_count_next);
            if (w_count_next > r_stat_max) r_stat_max <= w_count_next;
        end
    end

    assign o_stat_pid_total = r_stat_total;
    assign o_stat_max_pids  = r_stat_max;
`endif

    assign bus.in_ready      = w_in_ready;
    assign bus.mem_req_valid = r_req_valid;
    assign bus.mem_req_addr  = r_req_addr;
    assign bus.mem_req_data  = r_req_data;
    assign o_done            = w_done;
    assign o_tile_count      = r_tile_count;
    assign o_error           = r_error;

endmodule
